pipelined_addsub: RTL

- Parametrised, pipelined two's-complement add/subtract unit for the ALU datapath.
- Generalises the 32-bit ripple-borrow subtractor in four ways: configurable width, configurable chunk (stage) size, a runtime add/sub mode and status flags.
- The borrow/carry chain is split into CHUNK-bit slices, one slice per pipeline stage, so the critical path is one slice rather than the full word.
- A valid/ready handshake sits on both sides, with full backpressure; throughput is one operation per cycle.

---
 rtl/pipelined_addsub_pkg.sv | 24 ++
 rtl/pipelined_addsub_chunk.sv | 33 +++
 rtl/pipelined_addsub.sv | 113 +++++++++++
 3 files changed

// File: rtl/pipelined_addsub_pkg.sv
// Shared opcodes, status-flag bit positions and the overflow rule
// for the pipelined add/subtract unit.
package pipelined_addsub_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Flag bit positions when the flags are packed into an ALU status word.
    localparam int FLAG_C    = 0;
    localparam int FLAG_Z    = 1;
    localparam int FLAG_N    = 2;
    localparam int FLAG_V    = 3;
    localparam int NUM_FLAGS = 4;

    // Signed overflow from the operand and result sign bits.
    function automatic logic ovf_calc(input logic op, input logic a,
                                      input logic b, input logic r);
        if (op == OP_SUB)
            return (a != b) && (r != a);
        else
            return (a == b) && (r != a);
    endfunction

endpackage

// File: rtl/pipelined_addsub_chunk.sv
// Combinational CHUNK-bit add/subtract slice with carry/borrow chain.
module addsub_chunk
    import pipelined_addsub_pkg::*;
#(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             op,
    input  logic             chain_in,
    output logic [CHUNK-1:0] res,
    output logic             chain_out,
    output logic             slice_zero
);

    // Ripple the chain bit through the slice; carry for add, borrow for sub.
    always_comb begin
        logic c;
        c   = chain_in;
        res = '0;
        for (int i = 0; i < CHUNK; i++) begin
            res[i] = a[i] ^ b[i] ^ c;
            if (op == OP_SUB)
                c = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & c);
            else
                c = (a[i] & b[i]) | ((a[i] ^ b[i]) & c);
        end
        chain_out = c;
    end

    assign slice_zero = ~|res;

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement add/subtract: one CHUNK-bit slice of the
// chain per stage, valid/ready on both sides with a global stall.
module pipelined_addsub
    import pipelined_addsub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_cout,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_ovf
);

    localparam int STAGES = WIDTH / CHUNK;
    localparam int LAST   = STAGES - 1;

    if (WIDTH % CHUNK != 0) begin : g_bad_width
        $error("pipelined_addsub: WIDTH must be a multiple of CHUNK");
    end

    // Per-stage state: operands travel whole, finished slices accumulate in r_res.
    logic [STAGES-1:0]            r_vld, r_op, r_chain, r_zero;
    logic [STAGES-1:0][WIDTH-1:0] r_a, r_b, r_res;

    // Stage inputs: stage 0 from the ports, stage k from stage k-1.
    logic [STAGES-1:0]            w_src_vld, w_src_op, w_src_chain, w_src_zero;
    logic [STAGES-1:0][WIDTH-1:0] w_src_a, w_src_b, w_src_res;
    logic [STAGES-1:0][CHUNK-1:0] w_slice;
    logic [STAGES-1:0]            w_cout, w_szero;
    logic                         w_adv;

    // Whole pipe moves together; only a held output result can stop it.
    assign w_adv    = !r_vld[LAST] || out_ready;
    assign in_ready = w_adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign w_src_vld[k]   = in_valid;
            assign w_src_op[k]    = in_op;
            assign w_src_a[k]     = in_a;
            assign w_src_b[k]     = in_b;
            assign w_src_res[k]   = '0;
            assign w_src_chain[k] = 1'b0;
            assign w_src_zero[k]  = 1'b1;
        end else begin : g_body
            assign w_src_vld[k]   = r_vld[k-1];
            assign w_src_op[k]    = r_op[k-1];
            assign w_src_a[k]     = r_a[k-1];
            assign w_src_b[k]     = r_b[k-1];
            assign w_src_res[k]   = r_res[k-1];
            assign w_src_chain[k] = r_chain[k-1];
            assign w_src_zero[k]  = r_zero[k-1];
        end

        addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
            .a          (w_src_a[k][k*CHUNK +: CHUNK]),
            .b          (w_src_b[k][k*CHUNK +: CHUNK]),
            .op         (w_src_op[k]),
            .chain_in   (w_src_chain[k]),
            .res        (w_slice[k]),
            .chain_out  (w_cout[k]),
            .slice_zero (w_szero[k])
        );
    end

    // Advance every stage on w_adv; reset drops all in-flight beats and zeroes data.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld   <= '0;
            r_op    <= '0;
            r_chain <= '0;
            r_zero  <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
        end else if (w_adv) begin
            for (int k = 0; k < STAGES; k++) begin
                r_vld[k]                   <= w_src_vld[k];
                r_op[k]                    <= w_src_op[k];
                r_a[k]                     <= w_src_a[k];
                r_b[k]                     <= w_src_b[k];
                r_chain[k]                 <= w_cout[k];
                r_zero[k]                  <= w_src_zero[k] & w_szero[k];
                r_res[k]                   <= w_src_res[k];
                r_res[k][k*CHUNK +: CHUNK] <= w_slice[k];
            end
        end
    end

    assign out_valid  = r_vld[LAST];
    assign out_result = r_res[LAST];
    assign out_cout   = r_chain[LAST];
    assign out_zero   = r_zero[LAST];
    assign out_neg    = r_res[LAST][WIDTH-1];
    assign out_ovf    = ovf_calc(r_op[LAST], r_a[LAST][WIDTH-1],
                                 r_b[LAST][WIDTH-1], r_res[LAST][WIDTH-1]);

    // Low operand bits are dead once their slice is done; sink them here.
    logic w_unused;
    assign w_unused = ^{r_a, r_b};

endmodule
